// File: rtl/fas_frame_ctrl_if.sv
// Observation and result bundle between the FAS datapath strobes and the
// frame sequencer. The datapath side (master) drives the strobes; the
// sequencer (slave) drives frame/result status back.
interface fas_frame_ctrl_if #(
    parameter int FRAME_LEN = 16,
    parameter int FRAME_W   = 8
);
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic               fir_valid;
    logic               fft_valid;
    logic               done;
    logic [3:0]         freq;

    logic [IDX_W-1:0]   sample_idx;
    logic               frame_start;
    logic               busy;
    logic               res_valid;
    logic [3:0]         res_freq;
    logic [FRAME_W-1:0] res_frame;
    logic [7:0]         drop_cnt;
    logic               overrun;
    logic               timeout_err;

    modport master (
        output fir_valid, fft_valid, done, freq,
        input  sample_idx, frame_start, busy, res_valid, res_freq,
               res_frame, drop_cnt, overrun, timeout_err
    );

    modport slave (
        input  fir_valid, fft_valid, done, freq,
        output sample_idx, frame_start, busy, res_valid, res_freq,
               res_frame, drop_cnt, overrun, timeout_err
    );
endinterface

// File: rtl/fas_frame_ctrl.sv
// Frame sequencer/monitor for FIR -> FFT -> peak analyzer. Counts FIR samples
// into frames, follows one frame at a time through the FFT and analyzer
// strobes, posts a tagged result per frame, and flags dropped frames and
// stalled stages. Purely observational: never gates the datapath.
module fas_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int FRAME_W   = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            rst,
    fas_frame_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int WAIT_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);
    localparam logic [FRAME_W-1:0] TAG_ZERO  = FRAME_W'(0);
    localparam logic [FRAME_W-1:0] TAG_ONE   = FRAME_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_FFT = 2'd1;
    localparam logic [1:0] ST_WAIT_ANA = 2'd2;
    localparam logic [1:0] ST_REPORT   = 2'd3;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [IDX_W-1:0]   sample_idx_r;
    logic               frame_start_r;
    logic [FRAME_W-1:0] fcnt_r;
    logic [FRAME_W-1:0] cur_tag_r;
    logic [FRAME_W-1:0] cur_tag_nxt_s;
    logic               pend_v_r;
    logic [FRAME_W-1:0] pend_tag_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               busy_r;
    logic               res_valid_r;
    logic [3:0]         res_freq_r;
    logic [FRAME_W-1:0] res_frame_r;
    logic [7:0]         drop_cnt_r;
    logic               overrun_r;
    logic               timeout_err_r;

    logic boundary_s;
    logic post_s;
    logic drop_s;
    logic pend_set_s;
    logic pend_clr_s;
    logic tmo_s;
    logic wait_clr_s;
    logic nxt_waiting_s;

    assign boundary_s    = bus.fir_valid & (sample_idx_r == IDX_LAST);
    assign nxt_waiting_s = (state_nxt_s == ST_WAIT_FFT) | (state_nxt_s == ST_WAIT_ANA);

    // Next-state decode: frame acceptance, drops, result posting and timeouts.
    always_comb begin
        state_nxt_s   = state_r;
        cur_tag_nxt_s = cur_tag_r;
        post_s        = 1'b0;
        drop_s        = 1'b0;
        pend_set_s    = 1'b0;
        pend_clr_s    = 1'b0;
        tmo_s         = 1'b0;
        wait_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (boundary_s) begin
                    state_nxt_s   = ST_WAIT_FFT;
                    cur_tag_nxt_s = fcnt_r;
                    wait_clr_s    = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_WAIT_FFT: begin
                drop_s = boundary_s;
                if (bus.fft_valid) begin
                    wait_clr_s = 1'b1;
                    if (bus.done) begin
                        state_nxt_s = ST_REPORT;
                        post_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_ANA;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_FFT;
                end
            end
            ST_WAIT_ANA: begin
                if (bus.done) begin
                    // A frame closing on the same cycle as the result is
                    // parked and picked up in REPORT instead of dropped.
                    state_nxt_s = ST_REPORT;
                    post_s      = 1'b1;
                    pend_set_s  = boundary_s;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    drop_s      = boundary_s;
                    state_nxt_s = ST_IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    drop_s      = boundary_s;
                    state_nxt_s = ST_WAIT_ANA;
                end
            end
            ST_REPORT: begin
                if (pend_v_r) begin
                    state_nxt_s   = ST_WAIT_FFT;
                    cur_tag_nxt_s = pend_tag_r;
                    pend_clr_s    = 1'b1;
                    wait_clr_s    = 1'b1;
                    drop_s        = boundary_s;
                end else if (boundary_s) begin
                    state_nxt_s   = ST_WAIT_FFT;
                    cur_tag_nxt_s = fcnt_r;
                    wait_clr_s    = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sample/frame counters: free-running with the FIR stream, independent of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_idx_r  <= IDX_ZERO;
            frame_start_r <= 1'b0;
            fcnt_r        <= TAG_ZERO;
        end else begin
            frame_start_r <= bus.fir_valid & (sample_idx_r == IDX_ZERO);
            if (bus.fir_valid) begin
                sample_idx_r <= sample_idx_r + IDX_ONE;
            end
            if (boundary_s) begin
                fcnt_r <= fcnt_r + TAG_ONE;
            end
        end
    end

    // FSM state, current/pending tags, wait counter and busy decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cur_tag_r  <= TAG_ZERO;
            pend_v_r   <= 1'b0;
            pend_tag_r <= TAG_ZERO;
            wait_cnt_r <= WAIT_ZERO;
            busy_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cur_tag_r <= cur_tag_nxt_s;
            busy_r    <= nxt_waiting_s;
            if (pend_set_s) begin
                pend_v_r   <= 1'b1;
                pend_tag_r <= fcnt_r;
            end else if (pend_clr_s) begin
                pend_v_r   <= 1'b0;
            end
            if (wait_clr_s || !nxt_waiting_s) begin
                wait_cnt_r <= WAIT_ZERO;
            end else begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end
        end
    end

    // Result posting and sticky error/drop bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r   <= 1'b0;
            res_freq_r    <= 4'd0;
            res_frame_r   <= TAG_ZERO;
            drop_cnt_r    <= 8'd0;
            overrun_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            res_valid_r <= post_s;
            if (post_s) begin
                res_freq_r  <= bus.freq;
                res_frame_r <= cur_tag_r;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
                if (drop_cnt_r != 8'd255) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end
            end
            if (tmo_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign bus.sample_idx  = sample_idx_r;
    assign bus.frame_start = frame_start_r;
    assign bus.busy        = busy_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_freq    = res_freq_r;
    assign bus.res_frame   = res_frame_r;
    assign bus.drop_cnt    = drop_cnt_r;
    assign bus.overrun     = overrun_r;
    assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Self-checking bench for fas_frame_ctrl: directed scenarios followed by
// randomized pipeline traffic, compared against a frame-level reference model.
module tb_fas_frame_ctrl;
    localparam int FL = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fas_frame_ctrl_if #(.FRAME_LEN(FL), .FRAME_W(8)) bus ();
    fas_frame_ctrl #(.FRAME_LEN(FL), .FRAME_W(8), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (frame-level view)
    int         m_idx;
    bit [7:0]   m_fcnt;
    int         m_drops;
    bit         m_over, m_tout, m_fs;
    bit         m_have, m_fft_seen, m_report;
    int         m_age;
    bit [7:0]   m_tag;
    bit [7:0]   m_pend_q[$];
    bit [3:0]   m_last_freq;
    bit [7:0]   m_last_tag;
    bit [11:0]  exp_q[$];
    int         stim_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_idx = 0; m_fcnt = 8'd0; m_drops = 0; m_over = 1'b0; m_tout = 1'b0;
        m_fs = 1'b0; m_have = 1'b0; m_fft_seen = 1'b0; m_report = 1'b0;
        m_age = 0; m_tag = 8'd0; m_last_freq = 4'd0; m_last_tag = 8'd0;
        m_pend_q.delete();
        exp_q.delete();
    endtask

    task automatic begin_frame(input bit [7:0] t);
        m_have = 1'b1; m_fft_seen = 1'b0; m_age = 0; m_tag = t;
    endtask

    task automatic note_drop();
        m_over = 1'b1;
        if (m_drops < 255) m_drops++;
    endtask

    task automatic post(input bit [3:0] fq);
        m_have = 1'b0; m_report = 1'b1;
        m_last_freq = fq; m_last_tag = m_tag;
        exp_q.push_back({m_tag, fq});
    endtask

    task automatic expire();
        m_have = 1'b0; m_tout = 1'b1;
    endtask

    task automatic model_step(input bit fv, input bit ffv, input bit dn, input bit [3:0] fq);
        bit bnd, was_report;
        bnd = fv && (m_idx == FL - 1);
        m_fs = fv && (m_idx == 0);
        was_report = m_report;
        m_report = 1'b0;
        if (was_report) begin
            if (m_pend_q.size() > 0) begin
                begin_frame(m_pend_q.pop_front());
                if (bnd) note_drop();
            end else if (bnd) begin
                begin_frame(m_fcnt);
            end
        end else if (!m_have) begin
            if (bnd) begin_frame(m_fcnt);
        end else if (!m_fft_seen) begin
            if (bnd) note_drop();
            if (ffv && dn) post(fq);
            else if (ffv) begin m_fft_seen = 1'b1; m_age = 0; end
            else if (m_age == TO - 1) expire();
            else m_age++;
        end else begin
            if (dn) begin
                post(fq);
                if (bnd) m_pend_q.push_back(m_fcnt);
            end else begin
                if (bnd) note_drop();
                if (m_age == TO - 1) expire();
                else m_age++;
            end
        end
        if (bnd) m_fcnt++;
        if (fv) m_idx = (m_idx + 1) % FL;
    endtask

    // Model advances on every clock edge, and resets asynchronously with the DUT.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else model_step(bus.fir_valid, bus.fft_valid, bus.done, bus.freq);
        end
    end

    // Per-cycle status comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("sample_idx", 32'(bus.sample_idx), 32'(m_idx));
            chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
            chk("busy", 32'(bus.busy), 32'(m_have));
            chk("res_valid", 32'(bus.res_valid), 32'(m_report));
            chk("res_freq_hold", 32'(bus.res_freq), 32'(m_last_freq));
            chk("res_frame_hold", 32'(bus.res_frame), 32'(m_last_tag));
            chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
            chk("overrun", 32'(bus.overrun), 32'(m_over));
            chk("timeout_err", 32'(bus.timeout_err), 32'(m_tout));
        end
    end

    // Scoreboard monitor: each posted result must match the oldest expected one.
    initial begin
        bit [11:0] e;
        forever begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("res_frame", 32'(bus.res_frame), 32'(e[11:4]));
                    chk("res_freq", 32'(bus.res_freq), 32'(e[3:0]));
                end
            end
        end
    end

    task automatic tick(input bit fv, input bit ffv, input bit dn, input bit [3:0] fq);
        bus.fir_valid = fv;
        bus.fft_valid = ffv;
        bus.done      = dn;
        bus.freq      = fq;
        if (fv) stim_idx = (stim_idx + 1) % FL;
        @(negedge clk);
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        int fft_cd, done_cd, p;
        bit fv, ffv, dn;
        bus.fir_valid = 1'b0; bus.fft_valid = 1'b0; bus.done = 1'b0; bus.freq = 4'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Nominal frames
        samples(16); idle(5); tick(1'b0, 1'b1, 1'b0, 4'd0); idle(2);
        tick(1'b0, 1'b0, 1'b1, 4'd9); idle(3);
        samples(16); idle(2); tick(1'b0, 1'b1, 1'b0, 4'd0); idle(1);
        tick(1'b0, 1'b0, 1'b1, 4'd6); idle(3);

        // Overrun: second frame completes while the first is still waiting
        samples(32); tick(1'b0, 1'b1, 1'b0, 4'd0); idle(1);
        tick(1'b0, 1'b0, 1'b1, 4'd3); idle(3);

        // Result and frame boundary on the same cycle
        samples(16); tick(1'b0, 1'b1, 1'b0, 4'd0);
        samples(15); tick(1'b1, 1'b0, 1'b1, 4'd12); idle(3);
        tick(1'b0, 1'b1, 1'b0, 4'd0); tick(1'b0, 1'b0, 1'b1, 4'd1); idle(3);

        // Timeout, then recovery
        samples(16); idle(70);
        samples(16); idle(4); tick(1'b0, 1'b1, 1'b0, 4'd0); idle(2);
        tick(1'b0, 1'b0, 1'b1, 4'd15); idle(3);

        // Asynchronous reset while waiting
        samples(16); idle(5);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_sample_idx", 32'(bus.sample_idx), 32'(0));
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'(0));
        chk("rst_overrun", 32'(bus.overrun), 32'(0));
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'(0));
        chk("rst_res_frame", 32'(bus.res_frame), 32'(0));
        stim_idx = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        samples(16); idle(3); tick(1'b0, 1'b1, 1'b1, 4'd7); idle(3);

        // Continuous samples, no FFT: drop counter must saturate
        samples(6400);
        chk("drop_saturated", 32'(bus.drop_cnt), 32'(255));
        idle(80);

        // Randomized pipeline traffic
        fft_cd = -1; done_cd = -1; p = 80;
        for (int c = 0; c < 8000; c++) begin
            if (c % 500 == 0) p = (c % 1500 == 0) ? 30 : ((c % 1000 == 0) ? 95 : 75);
            fv = ($urandom_range(0, 99) < p);
            ffv = 1'b0; dn = 1'b0;
            if (fft_cd == 0) begin
                ffv = 1'b1; fft_cd = -1; done_cd = $urandom_range(0, 6);
            end else if (fft_cd > 0) begin
                fft_cd--;
            end
            if (done_cd == 0) begin
                dn = 1'b1; done_cd = -1;
            end else if (done_cd > 0) begin
                done_cd--;
            end
            if ($urandom_range(0, 63) == 0) ffv = 1'b1;
            if ($urandom_range(0, 63) == 0) dn = 1'b1;
            if (fv && stim_idx == FL - 1 && fft_cd < 0 && done_cd < 0)
                fft_cd = ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(0, 12);
            tick(fv, ffv, dn, 4'($urandom_range(0, 15)));
        end
        idle(100);
        chk("results_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fas_frame_ctrl.md
# fas_frame_ctrl

Frame sequencer and monitor for the FAS pipeline: FIR filter → 16-point FFT → peak-frequency analyzer. It tracks the FIR output stream into 16-sample frames, follows each frame through the FFT and analyzer handshakes, and posts one tagged frequency result per frame. It also detects frame overruns and stalled stages. It sits beside the FIR/FFT/Analyzer instances inside FAS and only observes their strobes; it never gates the datapath.

## Interface
Parameters:
- FRAME_LEN, 16, FIR samples per FFT frame (power of two; FFT size)
- FRAME_W, 8, width of frame counters/tags
- TIMEOUT, 64, max cycles allowed in any wait state before error

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- fir_valid  input  1  FIR output sample strobe (one sample per high cycle)
- fft_valid  input  1  FFT frame-complete strobe (1-cycle pulse)
- done  input  1  analyzer result strobe (1-cycle pulse)
- freq  input  4  analyzer peak bin, valid when done=1
- sample_idx  output  log2(FRAME_LEN)  index of next FIR sample within frame
- frame_start  output  1  pulse: sample 0 of a frame accepted
- busy  output  1  high in WAIT_FFT or WAIT_ANA
- res_valid  output  1  pulse: result posted
- res_freq  output  4  latched freq of posted result
- res_frame  output  FRAME_W  tag of frame that produced res_freq
- drop_cnt  output  8  frames completed while pipeline busy (saturates at 255)
- overrun  output  1  sticky: at least one frame dropped
- timeout_err  output  1  sticky: a wait state hit TIMEOUT

## Operation
- sample_idx increments on every fir_valid, wraps FRAME_LEN-1 → 0; runs independently of FSM state. frame_start = fir_valid & (sample_idx==0), registered.
- boundary event = fir_valid & (sample_idx==FRAME_LEN-1).
- frame tag fcnt (internal, FRAME_W bits, wraps) increments on every boundary event, accepted or dropped.
- FSM states: IDLE, WAIT_FFT, WAIT_ANA, REPORT.
  - IDLE: boundary → WAIT_FFT, capture cur_tag=fcnt.
  - WAIT_FFT: fft_valid → WAIT_ANA. If done also high same cycle → REPORT (latch freq).
  - WAIT_ANA: done → REPORT, latch freq.
  - REPORT: one cycle; res_valid=1. Next IDLE, or WAIT_FFT if boundary in this cycle (new tag captured).
- Boundary in WAIT_FFT or WAIT_ANA: frame dropped, drop_cnt+1 (saturating), overrun←1; FSM unaffected.
- Boundary in WAIT_ANA in the same cycle as done: not a drop; FSM goes REPORT and that frame is accepted in REPORT→WAIT_FFT with its tag held in a 1-entry pending register.
- Wait counter clears on entering WAIT_FFT/WAIT_ANA, counts each cycle there; reaching TIMEOUT-1 without the expected strobe → timeout_err←1, FSM → IDLE, no result posted.
- fft_valid or done in IDLE/REPORT: ignored.
- overrun, timeout_err clear only on reset.

## Timing
- Reset (rst=0, async): state IDLE; sample_idx, fcnt, drop_cnt, res_freq, res_frame, wait counter = 0; frame_start, busy, res_valid, overrun, timeout_err = 0.
- rst release synchronous to clk; first fir_valid after release is sample 0.
- res_valid high exactly one cycle, the cycle after done is sampled; res_freq/res_frame update in that same cycle and hold until next result.
- Latency done → res_valid: 1 cycle. Back-to-back frames: new frame can be accepted in REPORT cycle; no dead cycle.
- busy is a registered decode of state.
- Reset mid-frame: partial frame discarded, sample_idx restarts at 0.

## Test plan
- Reset: drive rst=0 mid-wait → all outputs 0 immediately (async), state IDLE; after release 16 fir_valid → frame_start once at sample 0, FSM WAIT_FFT.
- Nominal: 16 fir_valid, fft_valid 5 cycles later, done with freq=4'd9 3 cycles later → res_valid one cycle after done, res_freq=9, res_frame=0; second frame → res_frame=1.
- Overrun: 32 consecutive fir_valid with no fft_valid → drop_cnt=1, overrun=1, fcnt=2, still WAIT_FFT; then fft_valid, done freq=3 → res_frame=0, res_freq=3.
- Simultaneous: done in same cycle as 16th sample of next frame → res_valid next cycle, no drop (drop_cnt unchanged), FSM WAIT_FFT with res_frame+1 tag pending.
- Timeout: frame completes, fft_valid never arrives → at TIMEOUT=64 cycles timeout_err=1, busy=0, no res_valid; next frame processed normally.
- Wrap: run 256 frames (FRAME_W=8) → res_frame wraps 255→0; drop_cnt saturation with 300 dropped frames → holds 255.
